register_file_sb: RTL

//  Parametrised integer register file with a scoreboard and write-to-read bypass.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 87 ++++++++
 rtl/register_file_sb.sv | 87 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file.
package rf_pkg;

  // Default geometry of the integer register file.
  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int AW_DEFAULT       = $clog2(NUM_REGS_DEFAULT);

  // Register index at the default geometry.
  typedef logic [AW_DEFAULT-1:0] rf_addr_t;

  // Hardwired-zero register index.
  localparam rf_addr_t REG_ZERO = rf_addr_t'(0);

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Scoreboard for the register file: one busy bit per register, the
// reservation acceptance decision and a running count of reserved registers.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                release_enable,
  input  logic [AW-1:0]       release_reg,
  input  logic                reserve_enable,
  input  logic [AW-1:0]       reserve_reg,
  output logic [NUM_REGS-1:0] busy,
  output logic                reserve_ok,
  output logic [AW:0]         busy_count
);

  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
  localparam logic [AW:0]   COUNT_MAX = (AW+1)'(NUM_REGS - 1);

  logic [NUM_REGS-1:0] busy_r;
  logic [AW:0]         count_r;
  logic                release_valid_s;
  logic                releasing_s;
  logic                release_busy_s;
  logic                reserve_ok_s;

  // Decide release/reserve effects for this cycle; a release to the same
  // register lets a new producer take it over without a stall.
  always_comb begin
    release_valid_s = release_enable && (release_reg != ZERO_ADDR);
    releasing_s     = release_valid_s && (release_reg == reserve_reg);
    release_busy_s  = release_valid_s && busy_r[release_reg];
    reserve_ok_s    = 1'b0;
    if (reserve_enable && (reserve_reg != ZERO_ADDR)) begin
      reserve_ok_s = !busy_r[reserve_reg] || releasing_s;
    end else begin
      reserve_ok_s = 1'b0;
    end
  end

  // Busy bits: release clears, accepted reservation sets (set wins on a tie).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      if (release_valid_s) begin
        busy_r[release_reg] <= 1'b0;
      end
      if (reserve_ok_s) begin
        busy_r[reserve_reg] <= 1'b1;
      end
    end
  end

  // Reserved-register counter; a release of a non-busy register is a no-op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {(AW+1){1'b0}};
    end else begin
      case ({reserve_ok_s, release_busy_s})
        2'b10: begin
          if (count_r < COUNT_MAX) begin
            count_r <= count_r + {{AW{1'b0}}, 1'b1};
          end else begin
            count_r <= count_r;
          end
        end
        2'b01: begin
          if (count_r != {(AW+1){1'b0}}) begin
            count_r <= count_r - {{AW{1'b0}}, 1'b1};
          end else begin
            count_r <= count_r;
          end
        end
        default: count_r <= count_r;
      endcase
    end
  end

  assign busy       = busy_r;
  assign reserve_ok = reserve_ok_s;
  assign busy_count = count_r;

endmodule : rf_scoreboard

// File: rtl/register_file_sb.sv
// Integer register file with scoreboard and optional write-to-read bypass.
// Register 0 reads as zero and is never written or reserved.
module register_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_READ*AW-1:0]   read_reg,
  output logic [NUM_READ*XLEN-1:0] read_data,
  output logic [NUM_READ-1:0]      read_ready,
  input  logic                     write_enable,
  input  logic [AW-1:0]            write_reg,
  input  logic [XLEN-1:0]          write_data,
  input  logic                     reserve_enable,
  input  logic [AW-1:0]            reserve_reg,
  output logic                     reserve_ok,
  output logic [AW:0]              busy_count
);

  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
  localparam logic          BYPASS_ON = (BYPASS != 0);

  logic [XLEN-1:0]     regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_s;

  // Register storage; writes to register 0 are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (write_enable && (write_reg != ZERO_ADDR)) begin
        regs_r[write_reg] <= write_data;
      end
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk            (clk),
    .reset_n        (reset_n),
    .release_enable (write_enable),
    .release_reg    (write_reg),
    .reserve_enable (reserve_enable),
    .reserve_reg    (reserve_reg),
    .busy           (busy_s),
    .reserve_ok     (reserve_ok),
    .busy_count     (busy_count)
  );

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
    logic [AW-1:0]   addr_s;
    logic [XLEN-1:0] data_s;
    logic            ready_s;

    assign addr_s = read_reg[gi*AW +: AW];

    // Read mux: zero register, then same-cycle forward, then stored value.
    always_comb begin
      data_s  = {XLEN{1'b0}};
      ready_s = 1'b1;
      if (addr_s == ZERO_ADDR) begin
        data_s  = {XLEN{1'b0}};
        ready_s = 1'b1;
      end else if (BYPASS_ON && write_enable && (write_reg == addr_s)) begin
        data_s  = write_data;
        ready_s = 1'b1;
      end else begin
        data_s  = regs_r[addr_s];
        ready_s = !busy_s[addr_s];
      end
    end

    assign read_data[gi*XLEN +: XLEN] = data_s;
    assign read_ready[gi]             = ready_s;
  end

endmodule : register_file_sb
